// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath sizes, base opcodes, immediate formats and the
// decode-to-execute payload.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SHAMT,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   mux_result;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc;
        logic              illegal;
    } ex_payload_t;

    // Shift-immediate forms carry only a 5-bit shamt; funct7 stays in the upper bits.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] op, input logic [2:0] f3);
        imm_fmt_e fmt;
        fmt = IMM_NONE;
        case (op)
            OP_IMM:                                 fmt = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:  fmt = IMM_I;
            OP_STORE:                               fmt = IMM_S;
            OP_BRANCH:                              fmt = IMM_B;
            OP_LUI, OP_AUIPC:                       fmt = IMM_U;
            OP_JAL:                                 fmt = IMM_J;
            default:                                fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic is_rv32i_op(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, writeback and execute-side signals of the decode stage.
interface decode_stage_if;
    import riscv_pkg::*;

    logic                if_valid_in;
    logic                if_ready_out;
    logic [31:0]         instr_in;
    logic [XLEN-1:0]     pc_in;
    logic                flush_in;
    logic                wb_en_in;
    logic [REG_AW-1:0]   wb_addr_in;
    logic [XLEN-1:0]     wb_data_in;
    logic                ex_valid_out;
    logic                ex_ready_in;
    logic [6:0]          opcode_out;
    logic [2:0]          funct3_out;
    logic [6:0]          funct7_out;
    logic [XLEN-1:0]     rs1_out;
    logic [XLEN-1:0]     rs2_out;
    logic [XLEN-1:0]     mux_result_out;
    logic [REG_AW-1:0]   rd_out;
    logic [XLEN-1:0]     pc_out;
    logic                illegal_out;

    modport master (
        output if_valid_in, instr_in, pc_in, flush_in,
               wb_en_in, wb_addr_in, wb_data_in, ex_ready_in,
        input  if_ready_out, ex_valid_out, opcode_out, funct3_out, funct7_out,
               rs1_out, rs2_out, mux_result_out, rd_out, pc_out, illegal_out
    );

    modport slave (
        input  if_valid_in, instr_in, pc_in, flush_in,
               wb_en_in, wb_addr_in, wb_data_in, ex_ready_in,
        output if_ready_out, ex_valid_out, opcode_out, funct3_out, funct7_out,
               rs1_out, rs2_out, mux_result_out, rd_out, pc_out, illegal_out
    );

endinterface

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one clocked write port; x0 reads zero.
module reg_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1_c,
    output logic [XLEN-1:0]   o_rdata2_c
);

    logic [XLEN-1:0] r_regs [NUM_REGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1_c = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2_c = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: registers one instruction, reads operands, builds ALU operand B.
// Define WB_BYPASS_EN to forward same-cycle writeback data into the operand reads.
module decode_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    logic              r_valid;
    ex_payload_t       r_out;
    ex_payload_t       w_next;
    logic              w_accept;
    logic [REG_AW-1:0] w_rs1_idx;
    logic [REG_AW-1:0] w_rs2_idx;
    logic [XLEN-1:0]   w_rf_rs1;
    logic [XLEN-1:0]   w_rf_rs2;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (imm_fmt(instr[6:0], instr[14:12]))
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_SHAMT: imm = {27'b0, instr[24:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'b0};
            IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

    assign w_rs1_idx = bus.instr_in[19:15];
    assign w_rs2_idx = bus.instr_in[24:20];

    reg_file u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .i_we       (bus.wb_en_in),
        .i_waddr    (bus.wb_addr_in),
        .i_wdata    (bus.wb_data_in),
        .i_raddr1   (w_rs1_idx),
        .i_raddr2   (w_rs2_idx),
        .o_rdata1_c (w_rf_rs1),
        .o_rdata2_c (w_rf_rs2)
    );

`ifdef WB_BYPASS_EN
    assign w_rs1_val = (bus.wb_en_in && bus.wb_addr_in != '0 && bus.wb_addr_in == w_rs1_idx)
                       ? bus.wb_data_in : w_rf_rs1;
    assign w_rs2_val = (bus.wb_en_in && bus.wb_addr_in != '0 && bus.wb_addr_in == w_rs2_idx)
                       ? bus.wb_data_in : w_rf_rs2;
`else
    assign w_rs1_val = w_rf_rs1;
    assign w_rs2_val = w_rf_rs2;
`endif

    assign bus.if_ready_out = !r_valid || bus.ex_ready_in;
    assign w_accept         = bus.if_valid_in && bus.if_ready_out && !bus.flush_in;

    // Decode of the incoming word; unknown opcodes still pass with a zero operand B.
    always_comb begin
        w_next         = '0;
        w_next.opcode  = bus.instr_in[6:0];
        w_next.funct3  = bus.instr_in[14:12];
        w_next.funct7  = bus.instr_in[31:25];
        w_next.rs1     = w_rs1_val;
        w_next.rs2     = w_rs2_val;
        w_next.rd      = bus.instr_in[11:7];
        w_next.pc      = bus.pc_in;
        w_next.illegal = !is_rv32i_op(bus.instr_in[6:0]);
        if (w_next.illegal) begin
            w_next.mux_result = '0;
        end else if (bus.instr_in[6:0] == OP_REG) begin
            w_next.mux_result = w_rs2_val;
        end else begin
            w_next.mux_result = imm_gen(bus.instr_in);
        end
    end

    // Flush beats accept and stall; a consumed slot keeps its data but drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (bus.flush_in) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= w_next;
        end else if (bus.ex_ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ex_valid_out   = r_valid;
    assign bus.opcode_out     = r_out.opcode;
    assign bus.funct3_out     = r_out.funct3;
    assign bus.funct7_out     = r_out.funct7;
    assign bus.rs1_out        = r_out.rs1;
    assign bus.rs2_out        = r_out.rs2;
    assign bus.mux_result_out = r_out.mux_result;
    assign bus.rd_out         = r_out.rd;
    assign bus.pc_out         = r_out.pc;
    assign bus.illegal_out    = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I vectors, stall, flush, bypass, reset.
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] mux;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] X5_SAME_CYCLE = 32'h0000_00AB;
`else
    localparam logic [31:0] X5_SAME_CYCLE = 32'h0000_0000;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] mux,
                                input logic [4:0] rd, input logic [31:0] pc, input logic ill);
        exp_t e;
        e = '{op: op, f3: f3, f7: f7, rs1: rs1, rs2: rs2, mux: mux, rd: rd, pc: pc, ill: ill};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_en_in   = 1'b1;
        bus.wb_addr_in = addr;
        bus.wb_data_in = data;
        step();
        bus.wb_en_in   = 1'b0;
    endtask

    // Presents one instruction until the stage is ready; the expectation enters the scoreboard
    // only for instructions that should reach execute.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input exp_t e, input bit track);
        bit ok;
        ok = 1'b0;
        bus.if_valid_in = 1'b1;
        bus.instr_in    = instr;
        bus.pc_in       = pc;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.if_ready_out && !bus.flush_in) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (track) sb.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout pc=0x%08h: if_ready_out never 1, expected 1", pc);
        end
        bus.if_valid_in = 1'b0;
    endtask

    // Monitor: every consumed output is matched in order against the scoreboard.
    always @(negedge clk) begin
        exp_t act;
        exp_t exp;
        if (!rst && bus.ex_valid_out && bus.ex_ready_in) begin
            n_checks++;
            act = mk(bus.opcode_out, bus.funct3_out, bus.funct7_out, bus.rs1_out, bus.rs2_out,
                     bus.mux_result_out, bus.rd_out, bus.pc_out, bus.illegal_out);
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output pc=0x%08h: got output, expected none", bus.pc_out);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL output pc=0x%08h: got op=%h f3=%h f7=%h rs1=%h rs2=%h mux=%h rd=%h pc=%h ill=%b, expected op=%h f3=%h f7=%h rs1=%h rs2=%h mux=%h rd=%h pc=%h ill=%b",
                             exp.pc, act.op, act.f3, act.f7, act.rs1, act.rs2, act.mux, act.rd, act.pc, act.ill,
                             exp.op, exp.f3, exp.f7, exp.rs1, exp.rs2, exp.mux, exp.rd, exp.pc, exp.ill);
                end
            end
        end
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.if_valid_in = 1'b0;
        bus.instr_in    = '0;
        bus.pc_in       = '0;
        bus.flush_in    = 1'b0;
        bus.wb_en_in    = 1'b0;
        bus.wb_addr_in  = '0;
        bus.wb_data_in  = '0;
        bus.ex_ready_in = 1'b1;
        step();
        step();
        chk("reset_ex_valid", 32'(bus.ex_valid_out), 32'h0);
        chk("reset_opcode", 32'(bus.opcode_out), 32'h0);
        chk("reset_mux", bus.mux_result_out, 32'h0);
        chk("reset_pc", bus.pc_out, 32'h0);
        chk("reset_illegal", 32'(bus.illegal_out), 32'h0);
        chk("reset_if_ready", 32'(bus.if_ready_out), 32'h1);
        rst = 1'b0;
        step();

        // addi x1,x0,5 with one-cycle latency
        issue(32'h0050_0093, 32'h100, mk(7'h13, 3'd0, 7'h00, 32'h0, 32'h0, 32'h5, 5'd1, 32'h100, 1'b0), 1'b1);
        chk("addi_latency_valid", 32'(bus.ex_valid_out), 32'h1);
        step();

        wb(5'd2, 32'h10);
        wb(5'd3, 32'h20);
        issue(32'h0031_0233, 32'h104, mk(7'h33, 3'd0, 7'h00, 32'h10, 32'h20, 32'h20, 5'd4, 32'h104, 1'b0), 1'b1);
        issue(32'hFE31_2E23, 32'h108, mk(7'h23, 3'd2, 7'h7F, 32'h10, 32'h20, 32'hFFFF_FFFC, 5'h1C, 32'h108, 1'b0), 1'b1);
        issue(32'hFE31_0CE3, 32'h10C, mk(7'h63, 3'd0, 7'h7F, 32'h10, 32'h20, 32'hFFFF_FFF8, 5'h19, 32'h10C, 1'b0), 1'b1);
        issue(32'h1234_50B7, 32'h110, mk(7'h37, 3'd5, 7'h09, 32'h0, 32'h20, 32'h1234_5000, 5'd1, 32'h110, 1'b0), 1'b1);
        issue(32'h4031_5093, 32'h114, mk(7'h13, 3'd5, 7'h20, 32'h10, 32'h20, 32'h3, 5'd1, 32'h114, 1'b0), 1'b1);
        step();

        // Three-cycle stall with the next instruction waiting
        bus.ex_ready_in = 1'b0;
        issue(32'h0010_0393, 32'h118, mk(7'h13, 3'd0, 7'h00, 32'h0, 32'h0, 32'h1, 5'd7, 32'h118, 1'b0), 1'b1);
        fork
            issue(32'h0020_0413, 32'h11C, mk(7'h13, 3'd0, 7'h00, 32'h0, 32'h10, 32'h2, 5'd8, 32'h11C, 1'b0), 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_if_ready", 32'(bus.if_ready_out), 32'h0);
                    chk("stall_valid", 32'(bus.ex_valid_out), 32'h1);
                    chk("stall_rd", 32'(bus.rd_out), 32'd7);
                    chk("stall_mux", bus.mux_result_out, 32'h1);
                end
                @(posedge clk);
                #1;
                bus.ex_ready_in = 1'b1;
                @(negedge clk);
                chk("release_held_rd", 32'(bus.rd_out), 32'd7);
                @(negedge clk);
                chk("release_next_rd", 32'(bus.rd_out), 32'd8);
                chk("release_next_valid", 32'(bus.ex_valid_out), 32'h1);
            end
        join
        step();

        // Flush while stalled with a pending instruction, then flush against a ready accept
        bus.ex_ready_in = 1'b0;
        issue(32'h0030_0493, 32'h120, '0, 1'b0);
        bus.if_valid_in = 1'b1;
        bus.instr_in    = 32'h0040_0513;
        bus.pc_in       = 32'h124;
        @(negedge clk);
        chk("flush_pre_if_ready", 32'(bus.if_ready_out), 32'h0);
        step();
        bus.flush_in = 1'b1;
        @(negedge clk);
        chk("flush_pre_valid", 32'(bus.ex_valid_out), 32'h1);
        step();
        @(negedge clk);
        chk("flush_valid", 32'(bus.ex_valid_out), 32'h0);
        chk("flush_if_ready", 32'(bus.if_ready_out), 32'h1);
        step();
        @(negedge clk);
        chk("flush_drops_incoming", 32'(bus.ex_valid_out), 32'h0);
        step();
        bus.flush_in    = 1'b0;
        bus.if_valid_in = 1'b0;
        bus.ex_ready_in = 1'b1;
        step();
        step();

        // Same-cycle writeback to x5 while addi x6,x5,0 is accepted
        bus.wb_en_in   = 1'b1;
        bus.wb_addr_in = 5'd5;
        bus.wb_data_in = 32'hAB;
        issue(32'h0002_8313, 32'h128, mk(7'h13, 3'd0, 7'h00, X5_SAME_CYCLE, 32'h0, 32'h0, 5'd6, 32'h128, 1'b0), 1'b1);
        bus.wb_en_in   = 1'b0;
        issue(32'h0002_8313, 32'h12C, mk(7'h13, 3'd0, 7'h00, 32'hAB, 32'h0, 32'h0, 5'd6, 32'h12C, 1'b0), 1'b1);

        // Writeback to x0 during accept of add x10,x0,x0 must leave zero
        bus.wb_en_in   = 1'b1;
        bus.wb_addr_in = 5'd0;
        bus.wb_data_in = 32'hDEAD;
        issue(32'h0000_0533, 32'h130, mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 5'd10, 32'h130, 1'b0), 1'b1);
        bus.wb_en_in   = 1'b0;
        issue(32'h0000_0533, 32'h134, mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 5'd10, 32'h134, 1'b0), 1'b1);

        issue(32'hFFFF_FFFF, 32'h138, mk(7'h7F, 3'd7, 7'h7F, 32'h0, 32'h0, 32'h0, 5'd31, 32'h138, 1'b1), 1'b1);
        step();

        // Asynchronous reset in the middle of a stall
        bus.ex_ready_in = 1'b0;
        issue(32'h0010_0393, 32'h13C, '0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(bus.ex_valid_out), 32'h0);
        chk("async_reset_pc", bus.pc_out, 32'h0);
        step();
        rst = 1'b0;
        bus.ex_ready_in = 1'b1;
        issue(32'h0001_0093, 32'h140, mk(7'h13, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 5'd1, 32'h140, 1'b0), 1'b1);
        step();
        step();

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
